// File: rtl/memory_access_cycle_if.sv
// Data-memory port between the M stage (master) and the data memory (slave).
// Latency: a transfer completes in the cycle where req and ready are both high.
// Backpressure: the memory holds ready low to stretch an access; the master holds req and the payload until then.
// Signals: req/we/addr/wdata from the master; ready/rdata from the slave.
interface memory_access_cycle_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input ready, rdata);
  modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/memory_access_cycle.sv
// M stage of the RV32 pipeline: word loads/stores on a variable-latency data port, then the M/W register.
// Latency: non-memory ops reach W after 1 cycle; memory ops after 1 + wait cycles (wait forced to end at TIMEOUT_CYCLES).
// Backpressure: StallM is high while an access is pending; upstream holds the M inputs and W receives bubbles.
// Ports: clk/rst; M-stage controls and data (RegWriteM..ALU_ResultM); dmem master port; StallM;
//        W-stage register outputs, combinational ResultW; sticky err_misalign / err_timeout.
module memory_access_cycle #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         RegWriteM,
  input  logic                         MemWriteM,
  input  logic                         ResultSrcM,
  input  logic [4:0]                   RD_M,
  input  logic [31:0]                  PCPlus4M,
  input  logic [31:0]                  WriteDataM,
  input  logic [31:0]                  ALU_ResultM,
  memory_access_cycle_if.master        dmem,
  output logic                         StallM,
  output logic                         RegWriteW,
  output logic                         ResultSrcW,
  output logic [4:0]                   RD_W,
  output logic [31:0]                  PCPlus4W,
  output logic [31:0]                  ALU_ResultW,
  output logic [31:0]                  ReadDataW,
  output logic [31:0]                  ResultW,
  output logic                         err_misalign,
  output logic                         err_timeout
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          access, aligned, is_load;
  logic          timeout, done;

  assign access  = MemWriteM | ResultSrcM;
  assign aligned = (ALU_ResultM[1:0] == 2'b00);
  assign is_load = ResultSrcM;

  assign dmem.we    = MemWriteM;
  assign dmem.addr  = ALU_ResultM;
  assign dmem.wdata = WriteDataM;

  // State register and wait counter. The counter restarts whenever an
  // access is launched from IDLE and counts non-ready cycles in BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        cnt <= '0;
      end else if (!dmem.ready) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (StallM) state_nxt = BUSY;
      BUSY:    if (done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. Reset masks the request in the same cycle so a BUSY access
  // is abandoned immediately; a ready with no request never counts.
  always_comb begin
    dmem.req = 1'b0;
    timeout  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: dmem.req = access & aligned;
        BUSY: begin
          dmem.req = 1'b1;
          timeout  = (cnt == CNT_LAST) & !dmem.ready;
        end
        default: dmem.req = 1'b0;
      endcase
    end
    done   = (dmem.req & dmem.ready) | timeout;
    StallM = dmem.req & !done;
  end

  // M/W pipeline register. While stalled only RegWriteW drops (bubble);
  // ReadDataW is zeroed for loads that could not return real data.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW    <= 1'b0;
      ResultSrcW   <= 1'b0;
      RD_W         <= '0;
      PCPlus4W     <= '0;
      ALU_ResultW  <= '0;
      ReadDataW    <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (StallM) begin
        RegWriteW <= 1'b0;
      end else begin
        RegWriteW   <= RegWriteM;
        ResultSrcW  <= ResultSrcM;
        RD_W        <= RD_M;
        PCPlus4W    <= PCPlus4M;
        ALU_ResultW <= ALU_ResultM;
        if (is_load) begin
          if (!aligned || timeout) begin
            ReadDataW <= '0;
          end else if (dmem.req && dmem.ready) begin
            ReadDataW <= dmem.rdata;
          end
        end
      end
      if (access && !aligned) err_misalign <= 1'b1;
      if (timeout)            err_timeout  <= 1'b1;
    end
  end

  assign ResultW = ResultSrcW ? ReadDataW : ALU_ResultW;

endmodule

// File: tb/tb_memory_access_cycle.sv
// Directed bench for memory_access_cycle: expected W records are queued when an op is driven
// and popped when the op leaves the stage; stall, request and flag behaviour checked per cycle.
module tb_memory_access_cycle;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        StallM, RegWriteW, ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW, ResultW;
  logic        err_misalign, err_timeout;

  always #5 clk = ~clk;

  memory_access_cycle_if dmem_if ();

  memory_access_cycle #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .RegWriteM    (RegWriteM),
    .MemWriteM    (MemWriteM),
    .ResultSrcM   (ResultSrcM),
    .RD_M         (RD_M),
    .PCPlus4M     (PCPlus4M),
    .WriteDataM   (WriteDataM),
    .ALU_ResultM  (ALU_ResultM),
    .dmem         (dmem_if),
    .StallM       (StallM),
    .RegWriteW    (RegWriteW),
    .ResultSrcW   (ResultSrcW),
    .RD_W         (RD_W),
    .PCPlus4W     (PCPlus4W),
    .ALU_ResultW  (ALU_ResultW),
    .ReadDataW    (ReadDataW),
    .ResultW      (ResultW),
    .err_misalign (err_misalign),
    .err_timeout  (err_timeout)
  );

  typedef struct {
    logic        rw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdw;
    logic [31:0] res;
  } wexp_t;

  wexp_t       sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_rdw = '0;
  logic        exp_mis = 1'b0;
  logic        exp_to  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag);
    wexp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s.sb: observed empty scoreboard expected a queued record", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".RegWriteW"},   32'(RegWriteW),  32'(e.rw));
    chk({tag, ".ResultSrcW"},  32'(ResultSrcW), 32'(e.rs));
    chk({tag, ".RD_W"},        32'(RD_W),       32'(e.rd));
    chk({tag, ".PCPlus4W"},    PCPlus4W,        e.pc);
    chk({tag, ".ALU_ResultW"}, ALU_ResultW,     e.alu);
    chk({tag, ".ReadDataW"},   ReadDataW,       e.rdw);
    chk({tag, ".ResultW"},     ResultW,         e.res);
  endtask

  // wait_n: cycle (from issue) on which ready is raised; negative = never.
  task automatic do_op(input string tag, input logic rw, input logic mw, input logic rs,
                       input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] wd,
                       input logic [31:0] alu, input int wait_n, input logic [31:0] rdata);
    bit acc, al, tmo;
    int exp_stall;
    int reqs;
    acc  = mw | rs;
    al   = (alu[1:0] == 2'b00);
    tmo  = acc && al && (wait_n < 0 || wait_n > T);
    reqs = 0;
    if (!acc || !al)  exp_stall = 0;
    else if (tmo)     exp_stall = T;
    else              exp_stall = wait_n;
    if (rs) exp_rdw = (acc && al && !tmo) ? rdata : 32'h0;
    if (acc && !al) exp_mis = 1'b1;
    if (tmo)        exp_to  = 1'b1;
    sb.push_back('{rw, rs, rd, pc, alu, exp_rdw, rs ? exp_rdw : alu});

    @(negedge clk);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
    PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu;
    for (int c = 0; c <= exp_stall; c++) begin
      if (c > 0) @(negedge clk);
      dmem_if.ready = (c == wait_n);
      dmem_if.rdata = (c == wait_n) ? rdata : (32'hBAD0_0000 | 32'(c));
      #1;
      chk({tag, ".StallM"}, 32'(StallM), 32'(c < exp_stall));
      chk({tag, ".req"}, 32'(dmem_if.req), 32'(acc && al));
      if (dmem_if.req === 1'b1) begin
        reqs++;
        chk({tag, ".we"},    32'(dmem_if.we), 32'(mw));
        chk({tag, ".addr"},  dmem_if.addr,    alu);
        chk({tag, ".wdata"}, dmem_if.wdata,   wd);
      end
      @(posedge clk);
      #1;
      if (c < exp_stall) chk({tag, ".bubble"}, 32'(RegWriteW), 32'h0);
      else               chk_w(tag);
    end
    chk({tag, ".req_cycles"}, 32'(reqs), (acc && al) ? 32'(exp_stall + 1) : 32'h0);
    chk({tag, ".err_misalign"}, 32'(err_misalign), 32'(exp_mis));
    chk({tag, ".err_timeout"},  32'(err_timeout),  32'(exp_to));
  endtask

  initial begin
    rst = 1'b1;
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; RD_M = '0;
    PCPlus4M = '0; WriteDataM = '0; ALU_ResultM = '0;
    dmem_if.ready = 1'b0; dmem_if.rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.RegWriteW", 32'(RegWriteW), 32'h0);
    chk("reset.ResultW",   ResultW,        32'h0);
    chk("reset.StallM",    32'(StallM),    32'h0);
    chk("reset.req",       32'(dmem_if.req), 32'h0);
    chk("reset.flags",     32'({err_misalign, err_timeout}), 32'h0);
    rst = 1'b0;

    do_op("alu",     1, 0, 0, 5'd5, 32'h1004, 32'h0,        32'h1234, -1, 32'h0);
    do_op("ld0",     1, 0, 1, 5'd6, 32'h1008, 32'h0,        32'h0100,  0, 32'hDEADBEEF);
    do_op("st3",     0, 1, 0, 5'd0, 32'h100C, 32'hA5A5A5A5, 32'h0040,  3, 32'h0);
    do_op("ld2",     1, 0, 1, 5'd3, 32'h1010, 32'h0,        32'h0080,  2, 32'h0BADF00D);
    do_op("alu_rdy", 1, 0, 0, 5'd4, 32'h1014, 32'h0,        32'h5678,  0, 32'h77777777);
    do_op("ld_to",   1, 0, 1, 5'd8, 32'h1018, 32'h0,        32'h0104, -1, 32'h0);
    do_op("ld_mis",  1, 0, 1, 5'd9, 32'h101C, 32'h0,        32'h0102,  0, 32'h11111111);
    do_op("st_mis",  0, 1, 0, 5'd0, 32'h1020, 32'hCAFEF00D, 32'h0103,  0, 32'h0);

    // Reset while a load is waiting in BUSY.
    @(negedge clk);
    RegWriteM = 1; MemWriteM = 0; ResultSrcM = 1; RD_M = 5'd7;
    PCPlus4M = 32'h1024; WriteDataM = '0; ALU_ResultM = 32'h0200;
    dmem_if.ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.pre_stall", 32'(StallM), 32'h1);
    rst = 1'b1;
    dmem_if.ready = 1'b1;
    dmem_if.rdata = 32'h99999999;
    #1;
    chk("rst.req",    32'(dmem_if.req), 32'h0);
    chk("rst.StallM", 32'(StallM),      32'h0);
    @(posedge clk);
    #1;
    sb.delete();
    exp_rdw = '0; exp_mis = 1'b0; exp_to = 1'b0;
    chk("rst.W", 32'({RegWriteW, ResultSrcW, RD_W}), 32'h0);
    chk("rst.PCPlus4W",    PCPlus4W,    32'h0);
    chk("rst.ALU_ResultW", ALU_ResultW, 32'h0);
    chk("rst.ReadDataW",   ReadDataW,   32'h0);
    chk("rst.ResultW",     ResultW,     32'h0);
    chk("rst.flags", 32'({err_misalign, err_timeout}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; RD_M = '0; ALU_ResultM = '0;
    dmem_if.ready = 1'b1;
    #1;
    chk("post_rst.req",    32'(dmem_if.req), 32'h0);
    chk("post_rst.StallM", 32'(StallM),      32'h0);
    @(posedge clk);
    #1;
    chk("post_rst.ReadDataW", ReadDataW, 32'h0);

    // Back-to-back single-wait loads: the second request appears the cycle after the first completes.
    do_op("b2b_a", 1, 0, 1, 5'd10, 32'h2004, 32'h0, 32'h0300, 1, 32'h12345678);
    do_op("b2b_b", 1, 0, 1, 5'd11, 32'h2008, 32'h0, 32'h0304, 1, 32'h87654321);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
